// File: rtl/cpu_sequencer.sv
// Instruction-phase sequencer (FETCH/DECODE/EXEC/WRITE) for the 4-bit computer datapath.
// Optional breakpoint support is compiled in with `define BREAKPOINT_EN.
module cpu_sequencer #(
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int unsigned EXEC_WAIT   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step_req,
    output logic       step_ack,
    input  logic [3:0] opcode,
    input  logic       ctrl_pc_load,
    input  logic       ctrl_ram_we,
    input  logic       ctrl_acc_en,
    input  logic [3:0] pc_value,
`ifdef BREAKPOINT_EN
    input  logic [3:0] bkpt_addr,
    output logic       bkpt_hit,
`endif
    output logic       fetch_en,
    output logic       cp,
    output logic       acc_we,
    output logic       ram_we,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       busy,
    output logic       halted,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(EXEC_WAIT);

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic        step_mode_q, step_mode_d;
    logic        step_armed_q, step_armed_d;
    logic        run_armed_q, run_armed_d;
    logic [7:0]  instr_count_q, instr_count_d;

    logic fetch_q, cp_q, acc_we_q, ram_we_q, pc_inc_q, pc_load_q;
    logic busy_q, halted_q, step_ack_q;
    logic bkpt_match;

`ifdef BREAKPOINT_EN
    // Match is resolved inside FETCH, so the registered fetch strobe is gated here.
    assign bkpt_match = (state_q == S_FETCH) && !step_mode_q && (pc_value == bkpt_addr);
    assign bkpt_hit   = bkpt_match;
    assign fetch_en   = fetch_q && !bkpt_match;
`else
    logic unused_pc;
    assign unused_pc  = ^pc_value;
    assign bkpt_match = 1'b0;
    assign fetch_en   = fetch_q;
`endif

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        step_mode_d   = step_mode_q;
        step_armed_d  = step_armed_q | ~step_req;
`ifdef BREAKPOINT_EN
        run_armed_d   = run_armed_q | ~run;
`else
        run_armed_d   = 1'b1;
`endif
        instr_count_d = instr_count_q;

        case (state_q)
            S_IDLE: begin
                if (run && run_armed_q) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                end else if (step_req && step_armed_q) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (bkpt_match) begin
                    state_d     = S_IDLE;
                    run_armed_d = 1'b0;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                wait_d = '0;
                if (opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (wait_q == WAIT_LAST) begin
                    state_d       = S_WRITE;
                    instr_count_d = instr_count_q + 8'd1;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_WRITE: begin
                if (step_mode_q) begin
                    step_mode_d  = 1'b0;
                    step_armed_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (run && run_armed_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each is high for exactly its phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            step_mode_q   <= 1'b0;
            step_armed_q  <= 1'b1;
            run_armed_q   <= 1'b1;
            instr_count_q <= '0;
            fetch_q       <= 1'b0;
            cp_q          <= 1'b0;
            acc_we_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            step_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            step_mode_q   <= step_mode_d;
            step_armed_q  <= step_armed_d;
            run_armed_q   <= run_armed_d;
            instr_count_q <= instr_count_d;
            fetch_q       <= (state_d == S_FETCH);
            cp_q          <= (state_d == S_WRITE);
            acc_we_q      <= (state_d == S_WRITE) && ctrl_acc_en;
            ram_we_q      <= (state_d == S_WRITE) && ctrl_ram_we;
            pc_load_q     <= (state_d == S_WRITE) && ctrl_pc_load;
            pc_inc_q      <= (state_d == S_WRITE) && !ctrl_pc_load;
            busy_q        <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                             (state_d == S_EXEC)  || (state_d == S_WRITE);
            halted_q      <= (state_d == S_HALT);
            step_ack_q    <= (state_d == S_WRITE) && step_mode_q;
        end
    end

    assign cp          = cp_q;
    assign acc_we      = acc_we_q;
    assign ram_we      = ram_we_q;
    assign pc_inc      = pc_inc_q;
    assign pc_load     = pc_load_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign step_ack    = step_ack_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; breakpoint section builds with BREAKPOINT_EN.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, run, step_req, step_ack;
    logic [3:0] opcode, pc_value;
    logic       ctrl_pc_load, ctrl_ram_we, ctrl_acc_en;
    logic       fetch_en, cp, acc_we, ram_we, pc_inc, pc_load, busy, halted;
    logic [7:0] instr_count;
`ifdef BREAKPOINT_EN
    logic [3:0] bkpt_addr;
    logic       bkpt_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int acks;
    logic strobes;

    always #5 clk = ~clk;

    // Tiny datapath PC model: increments at the edge closing a WRITE with pc_inc.
    logic [3:0] pc_q;
    always @(posedge clk) begin
        if (!rst_n) pc_q <= '0;
        else if (pc_inc) pc_q <= pc_q + 4'd1;
    end
    assign pc_value = pc_q;

    cpu_sequencer #(
        .HALT_OPCODE(4'hF),
        .EXEC_WAIT  (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step_req    (step_req),
        .step_ack    (step_ack),
        .opcode      (opcode),
        .ctrl_pc_load(ctrl_pc_load),
        .ctrl_ram_we (ctrl_ram_we),
        .ctrl_acc_en (ctrl_acc_en),
        .pc_value    (pc_value),
`ifdef BREAKPOINT_EN
        .bkpt_addr   (bkpt_addr),
        .bkpt_hit    (bkpt_hit),
`endif
        .fetch_en    (fetch_en),
        .cp          (cp),
        .acc_we      (acc_we),
        .ram_we      (ram_we),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step_req = 1'b0; opcode = 4'h1;
        ctrl_pc_load = 1'b0; ctrl_ram_we = 1'b0; ctrl_acc_en = 1'b0;
`ifdef BREAKPOINT_EN
        bkpt_addr = 4'hF;
`endif
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_fetch", fetch_en, 0);
        check("rst_halted", halted, 0);
        check("rst_count", instr_count, 0);
        rst_n = 1'b1;

        // Reset asserted during EXEC aborts the instruction
        ctrl_acc_en = 1'b1; run = 1'b1;
        tick(); check("ab_fetch", fetch_en, 1); check("ab_busy", busy, 1);
        tick(); check("ab_dec_fetch", fetch_en, 0);
        tick(); check("ab_exec_cp", cp, 0);
        rst_n = 1'b0; run = 1'b0;
        tick();
        check("ab_acc_we", acc_we, 0); check("ab_cp", cp, 0);
        check("ab_busy0", busy, 0); check("ab_count", instr_count, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("ab_idle_cp", cp, 0); check("ab_idle_acc", acc_we, 0);

        // Free-run: opcodes 1,2,3, one instruction every 4 cycles
        run = 1'b1; opcode = 4'h1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("fr_fetch", fetch_en, 32'((k % 4) == 1));
            check("fr_cp", cp, 32'((k % 4) == 0));
            check("fr_acc_we", acc_we, 32'((k % 4) == 0));
            check("fr_pc_inc", pc_inc, 32'((k % 4) == 0));
            check("fr_pc_load", pc_load, 0);
            opcode = 4'(k / 4 + 1);
            if (k == 12) run = 1'b0;
        end
        check("fr_count", instr_count, 3);
        tick(); check("fr_idle", busy, 0);

        // run dropped mid-instruction still completes it
        run = 1'b1;
        tick(); check("rd_fetch", fetch_en, 1);
        run = 1'b0;
        tick(); tick(); tick();
        check("rd_cp", cp, 1); check("rd_count", instr_count, 4);
        tick(); check("rd_idle", busy, 0); check("rd_nofetch", fetch_en, 0);

        // Strobe gating from the control-ROM word
        ctrl_acc_en = 1'b0; ctrl_pc_load = 1'b1; ctrl_ram_we = 1'b1; run = 1'b1;
        tick(); run = 1'b0;
        tick(); tick(); tick();
        check("sg_pc_load", pc_load, 1); check("sg_ram_we", ram_we, 1);
        check("sg_pc_inc", pc_inc, 0); check("sg_acc_we", acc_we, 0);
        tick();
        ctrl_pc_load = 1'b0; ctrl_ram_we = 1'b0;

        // Single-step: held request gives exactly one instruction
        step_req = 1'b1; acks = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (step_ack) acks++;
            if (i == 4) check("st_ack_t4", step_ack, 1);
        end
        check("st_acks", acks, 1); check("st_count", instr_count, 6);
        step_req = 1'b0; tick();
        step_req = 1'b1; acks = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (step_ack) acks++;
        end
        check("st2_acks", acks, 1); check("st2_count", instr_count, 7);
        step_req = 1'b0; tick();

        // Halt opcode stops the sequencer until reset
        opcode = 4'hF; run = 1'b1;
        tick(); check("h_fetch", fetch_en, 1);
        tick();
        tick(); check("h_halted", halted, 1); check("h_busy", busy, 0);
        strobes = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_req = i[0];
            tick();
            strobes = strobes | fetch_en | cp | acc_we | ram_we | pc_inc | pc_load | step_ack | busy;
        end
        check("h_strobes", strobes, 0); check("h_still", halted, 1);
        check("h_count", instr_count, 7);
        run = 1'b0; step_req = 1'b0; opcode = 4'h1;
        do_reset();
        check("h_rst_halted", halted, 0);

`ifdef BREAKPOINT_EN
        // Breakpoint at address 3
        bkpt_addr = 4'h3; run = 1'b1; acks = 0;
        begin : bk_wait
            for (int i = 0; i < 40; i++) begin
                tick();
                if (bkpt_hit) disable bk_wait;
                if (fetch_en) acks++;
            end
        end
        check("bk_hit", bkpt_hit, 1); check("bk_nofetch", fetch_en, 0);
        check("bk_pc", pc_value, 3); check("bk_fetches", acks, 3);
        tick(); tick(); tick(); tick();
        check("bk_blocked", busy, 0);
        run = 1'b0; tick();
        run = 1'b1; tick();
        check("bk_hit2", bkpt_hit, 1); check("bk_nofetch2", fetch_en, 0);
        run = 1'b0; step_req = 1'b1; acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (step_ack) acks++;
        end
        check("bk_step_ack", acks, 1); check("bk_step_pc", pc_value, 4);
        step_req = 1'b0; run = 1'b1;
        tick();
        check("bk_resume", fetch_en, 1); check("bk_resume_hit", bkpt_hit, 0);
        run = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
